tmr_word_voter: RTL and testbench

- Parametrised, registered successor to the single-bit triple-modular-redundancy voter.
- Votes a WIDTH-bit word from three redundant channels on a strobe.
- Tracks per-channel miscompares and automatically retires a channel that miscompares ERR_LIMIT votes in a row.
- Degrades from 2-of-3 majority to duplex, then simplex; sits between triplicated logic and downstream single-string consumers.

---
 rtl/tmr_word_voter.sv | 197 +++++++++++++++++++
 tb/tb_tmr_word_voter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_word_voter.sv
`default_nettype none
// ============================================================================
// Module   : tmr_word_voter
// Purpose  : Registered triple-modular-redundancy word voter. It votes a
//            WIDTH-bit word from three redundant channels on each strobe and
//            tracks consecutive miscompares per channel. A channel that
//            miscompares ERR_LIMIT votes in a row is retired. The voter then
//            degrades from 2-of-3 majority to duplex, and then to simplex.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            vote            - sample and vote the three channels this cycle
//            clr             - clear all fail latches and miscompare counters
//            en[2:0]         - external channel enables
//            a1, a2, a3      - channel words
//            y               - registered voted word (inverted when INVERT=1)
//            valid           - one-cycle pulse on the cycle after a vote
//            miscmp[2:0]     - per-channel miscompare result of the last vote
//            fail[2:0]       - sticky per-channel retired flags
//            disagree        - last vote was duplex with unequal words
//            no_quorum       - last vote had no active channel
//            err_total[15:0] - saturating total of miscompare events
// Options  : define TMR_WORD_VOTER_ERRCNT_EN to build the err_total counter.
//            Without it, err_total is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_word_voter #(
   parameter int WIDTH     = 26,
   parameter int ERR_LIMIT = 3,
   parameter int CNT_W     = 4,
   parameter int INVERT    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vote,
   input  logic             clr,
   input  logic [2:0]       en,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] a2,
   input  logic [WIDTH-1:0] a3,
   output logic [WIDTH-1:0] y,
   output logic             valid,
   output logic [2:0]       miscmp,
   output logic [2:0]       fail,
   output logic             disagree,
   output logic             no_quorum,
   output logic [15:0]      err_total
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(ERR_LIMIT);
   localparam logic [WIDTH-1:0] Y_RST   = (INVERT != 0) ? '1 : '0;

   logic [CNT_W-1:0] cnt [3];
   logic [2:0]       act;
   logic [WIDTH-1:0] maj;
   logic [WIDTH-1:0] m;
   logic             upd;
   logic             dis_next;
   logic             nq_next;
   logic [2:0]       mis_next;

   assign act = en & ~fail;
   assign maj = (a1 & a2) | (a1 & a3) | (a2 & a3);

   // Vote resolution. When upd is low, y keeps its previous value.
   always_comb begin
      m        = '0;
      upd      = 1'b0;
      dis_next = 1'b0;
      nq_next  = 1'b0;
      mis_next = 3'b000;
      case (act)
         3'b111: begin
            m        = maj;
            upd      = 1'b1;
            mis_next = {a3 != maj, a2 != maj, a1 != maj};
         end
         3'b011: begin
            if (a1 == a2) begin
               m   = a1;
               upd = 1'b1;
            end else begin
               dis_next = 1'b1;
               mis_next = act;
            end
         end
         3'b101: begin
            if (a1 == a3) begin
               m   = a1;
               upd = 1'b1;
            end else begin
               dis_next = 1'b1;
               mis_next = act;
            end
         end
         3'b110: begin
            if (a2 == a3) begin
               m   = a2;
               upd = 1'b1;
            end else begin
               dis_next = 1'b1;
               mis_next = act;
            end
         end
         3'b001: begin
            m   = a1;
            upd = 1'b1;
         end
         3'b010: begin
            m   = a2;
            upd = 1'b1;
         end
         3'b100: begin
            m   = a3;
            upd = 1'b1;
         end
         default: nq_next = 1'b1;
      endcase
   end

   // Output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y         <= Y_RST;
         valid     <= 1'b0;
         miscmp    <= 3'b000;
         disagree  <= 1'b0;
         no_quorum <= 1'b0;
      end else begin
         valid <= vote;
         if (vote) begin
            miscmp    <= mis_next;
            disagree  <= dis_next;
            no_quorum <= nq_next;
            if (upd) begin
               y <= (INVERT != 0) ? ~m : m;
            end
         end
      end
   end

   // Consecutive-miscompare counters and retirement latches. A duplex
   // disagreement cannot identify the faulty channel, so it counts but
   // never retires. The count is kept, so a later triplex miscompare
   // (counter already at or past the limit) retires the channel at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
         fail <= 3'b000;
      end else if (clr) begin
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
         fail <= 3'b000;
      end else if (vote) begin
         for (int i = 0; i < 3; i++) begin
            if (mis_next[i]) begin
               if (cnt[i] != CNT_MAX) begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
               if (!dis_next && (cnt[i] + 1'b1 >= LIMIT || cnt[i] == CNT_MAX)) begin
                  fail[i] <= 1'b1;
               end
            end else if (act[i]) begin
               cnt[i] <= '0;
            end
         end
      end
   end

`ifdef TMR_WORD_VOTER_ERRCNT_EN
   logic [15:0] err_add;
   logic [15:0] err_q;

   assign err_add = 16'(mis_next[0]) + 16'(mis_next[1]) + 16'(mis_next[2]);

   // Cleared by reset only; clr leaves the lifetime total alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 16'h0000;
      end else if (vote) begin
         if (err_q > (16'hFFFF - err_add)) begin
            err_q <= 16'hFFFF;
         end else begin
            err_q <= err_q + err_add;
         end
      end
   end

   assign err_total = err_q;
`else
   assign err_total = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmr_word_voter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_word_voter
// Purpose  : Self-checking bench for tmr_word_voter. A behavioural model
//            follows the voting rules. Every cycle, the model is compared
//            with the design outputs. A directed sequence uses literal
//            expected values to pin the model. A randomized run follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_word_voter;

   localparam int W   = 26;
   localparam int LIM = 3;
   localparam int CW  = 4;
   localparam int INV = 1;
   localparam int CMAX = (1 << CW) - 1;
`ifdef TMR_WORD_VOTER_ERRCNT_EN
   localparam logic [31:0] ERR_EXP = 32'd4;
`else
   localparam logic [31:0] ERR_EXP = 32'd0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vote;
   logic          clr;
   logic [2:0]    en;
   logic [W-1:0]  a1, a2, a3;
   logic [W-1:0]  y;
   logic          valid;
   logic [2:0]    miscmp;
   logic [2:0]    fail;
   logic          disagree;
   logic          no_quorum;
   logic [15:0]   err_total;

   int vectors = 0;
   int errors  = 0;

   tmr_word_voter #(.WIDTH(W), .ERR_LIMIT(LIM), .CNT_W(CW), .INVERT(INV)) dut (
      .clk(clk), .rst_n(rst_n), .vote(vote), .clr(clr), .en(en),
      .a1(a1), .a2(a2), .a3(a3), .y(y), .valid(valid), .miscmp(miscmp),
      .fail(fail), .disagree(disagree), .no_quorum(no_quorum),
      .err_total(err_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_y;
   logic         m_valid, m_dis, m_nq;
   logic [2:0]   m_mis, m_fail;
   logic [15:0]  m_err;
   int           m_cnt [3];

   always @(posedge clk) begin
      logic [W-1:0] w [3];
      logic [W-1:0] val;
      logic [2:0]   mis, actv;
      logic         dis, nq, upd;
      int           idx [$];
      int           ones;
      if (!rst_n) begin
         m_y = (INV != 0) ? '1 : '0;
         m_valid = 0; m_dis = 0; m_nq = 0; m_mis = 0; m_fail = 0; m_err = 0;
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end else begin
         m_valid = 0;
         if (vote) begin
            w[0] = a1; w[1] = a2; w[2] = a3;
            idx.delete();
            for (int i = 0; i < 3; i++) begin
               actv[i] = en[i] && !m_fail[i];
               if (actv[i]) idx.push_back(i);
            end
            mis = 0; dis = 0; nq = 0; upd = 0; val = '0;
            if (idx.size() == 3) begin
               for (int b = 0; b < W; b++) begin
                  ones = int'(w[0][b]) + int'(w[1][b]) + int'(w[2][b]);
                  val[b] = (ones >= 2);
               end
               upd = 1;
               for (int i = 0; i < 3; i++) mis[i] = (w[i] != val);
            end else if (idx.size() == 2) begin
               if (w[idx[0]] == w[idx[1]]) begin
                  val = w[idx[0]]; upd = 1;
               end else begin
                  dis = 1; mis[idx[0]] = 1; mis[idx[1]] = 1;
               end
            end else if (idx.size() == 1) begin
               val = w[idx[0]]; upd = 1;
            end else begin
               nq = 1;
            end
            if (upd) m_y = (INV != 0) ? ~val : val;
            m_valid = 1; m_mis = mis; m_dis = dis; m_nq = nq;
`ifdef TMR_WORD_VOTER_ERRCNT_EN
            m_err = 16'((int'(m_err) + $countones(mis) > 65535) ? 65535
                        : int'(m_err) + $countones(mis));
`endif
            if (clr) begin
               m_fail = 0;
               for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end else begin
               for (int i = 0; i < 3; i++) begin
                  if (mis[i]) begin
                     m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                     if (!dis && m_cnt[i] >= LIM) m_fail[i] = 1;
                  end else if (actv[i]) begin
                     m_cnt[i] = 0;
                  end
               end
            end
         end else if (clr) begin
            m_fail = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
         end
      end
      #1;
      chk("y", 32'(y), 32'(m_y));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("miscmp", 32'(miscmp), 32'(m_mis));
      chk("fail", 32'(fail), 32'(m_fail));
      chk("disagree", 32'(disagree), 32'(m_dis));
      chk("no_quorum", 32'(no_quorum), 32'(m_nq));
      chk("err_total", 32'(err_total), 32'(m_err));
   end

   // ---------------- stimulus ----------------
   task automatic do_vote(input logic [2:0] e, input logic [W-1:0] x1,
                          input logic [W-1:0] x2, input logic [W-1:0] x3,
                          input logic c);
      @(negedge clk);
      en = e; a1 = x1; a2 = x2; a3 = x3; clr = c; vote = 1'b1;
      @(negedge clk);
      vote = 1'b0; clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] base;
      rst_n = 1'b0; vote = 1'b0; clr = 1'b0; en = 3'b111;
      a1 = '0; a2 = '0; a3 = '0;
      repeat (2) @(negedge clk);
      chk("rst_y", 32'(y), 32'h03FF_FFFF);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_fail", 32'(fail), 32'd0);
      chk("rst_err", 32'(err_total), 32'd0);
      rst_n = 1'b1;

      do_vote(3'b111, 26'h155_5555, 26'h155_5555, 26'h155_5555, 1'b0);
      chk("agree_y", 32'(y), 32'h02AA_AAAA);
      chk("agree_valid", 32'(valid), 32'd1);
      chk("agree_miscmp", 32'(miscmp), 32'd0);
      @(negedge clk);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_y", 32'(y), 32'h02AA_AAAA);

      for (int k = 0; k < 3; k++) begin
         do_vote(3'b111, 26'h1, 26'h0, 26'h0, 1'b0);
         chk("bad1_miscmp", 32'(miscmp), 32'd1);
         chk("bad1_fail", 32'(fail), (k == 2) ? 32'd1 : 32'd0);
      end
      do_vote(3'b111, 26'h1, 26'h0, 26'h0, 1'b0);
      chk("retired_miscmp", 32'(miscmp), 32'd0);
      chk("retired_y", 32'(y), 32'h03FF_FFFF);

      repeat (5) begin
         do_vote(3'b111, 26'h1, 26'h1, 26'h0, 1'b0);
         chk("duplex_dis", 32'(disagree), 32'd1);
         chk("duplex_y", 32'(y), 32'h03FF_FFFF);
         chk("duplex_miscmp", 32'(miscmp), 32'd6);
         chk("duplex_fail", 32'(fail), 32'd1);
      end

      do_vote(3'b000, 26'h1, 26'h2, 26'h3, 1'b0);
      chk("nq_flag", 32'(no_quorum), 32'd1);
      chk("nq_y", 32'(y), 32'h03FF_FFFF);
      do_vote(3'b100, 26'h0, 26'h0, 26'h3FF_FFFF, 1'b0);
      chk("simplex_y", 32'(y), 32'h0);
      chk("simplex_nq", 32'(no_quorum), 32'd0);

      // clr with vote: channel 0 is still retired for this vote's result
      do_vote(3'b111, 26'h1, 26'h0, 26'h0, 1'b1);
      chk("clr_fail", 32'(fail), 32'd0);
      chk("clr_miscmp", 32'(miscmp), 32'd0);
      chk("clr_y", 32'(y), 32'h03FF_FFFF);
      for (int k = 0; k < 3; k++) begin
         do_vote(3'b111, 26'h1, 26'h0, 26'h0, 1'b0);
         chk("post_clr_fail", 32'(fail), (k == 2) ? 32'd1 : 32'd0);
      end

      // reset in the middle of a vote strobe
      @(negedge clk);
      vote = 1'b1; rst_n = 1'b0;
      #1;
      chk("midrst_y", 32'(y), 32'h03FF_FFFF);
      chk("midrst_fail", 32'(fail), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      @(negedge clk);
      vote = 1'b0; rst_n = 1'b1;

      do_vote(3'b111, 26'h5, 26'h0, 26'h0, 1'b0);
      do_vote(3'b111, 26'h0, 26'h5, 26'h0, 1'b0);
      do_vote(3'b111, 26'h0, 26'h0, 26'h5, 1'b0);
      do_vote(3'b111, 26'h5, 26'h0, 26'h0, 1'b0);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      chk("err_after_clr", 32'(err_total), ERR_EXP);
      chk("err_fail_clr", 32'(fail), 32'd0);

      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 199) != 0);
         vote  = ($urandom_range(0, 9) < 6);
         clr   = ($urandom_range(0, 29) == 0);
         en    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
         base  = W'($urandom);
         a1 = base ^ (($urandom_range(0, 3) == 0) ? (W'(1) << $urandom_range(0, W-1)) : '0);
         a2 = base ^ (($urandom_range(0, 4) == 0) ? (W'(1) << $urandom_range(0, W-1)) : '0);
         a3 = base ^ (($urandom_range(0, 5) == 0) ? (W'(1) << $urandom_range(0, W-1)) : '0);
      end
      @(negedge clk);
      rst_n = 1'b1; vote = 1'b0; clr = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
